sdi_tx_ctrl: RTL and testbench
==============================

# sdi_tx_ctrl

Frame-synchronous controller for the HD-SDI transmit path, clocked on the SDI clock. It owns the video-mode setting and the path reset, and decides per frame whether the SDI output carries live stream data or the internal test pattern. It sits between the register/config interface and the stream-to-SMPTE converter / pattern generator pair. All source and mode switches occur only at frame boundaries, so the SDI output never carries a torn frame.

## Interface
Parameters:
- FILL_THRESH, 8000, FIFO read-count (words) required before switching to live.
- RST_CYCLES, 16, length of the path-reset pulse in clocks (≥2).
- UNDERRUN_LIMIT, 3, consecutive underrun frames that force fallback to pattern (≥1).
- DEFAULT_MODE, 3'd0, video mode after reset.

Ports:
- i_sdi_clk  in  1  sole clock.
- i_rst  in  1  synchronous, active-high reset.
- i_mode_req  in  3  requested video mode.
- i_mode_req_vld  in  1  one-cycle strobe qualifying i_mode_req.
- i_fifo_rd_count  in  14  converter FIFO read-side word count.
- i_fifo_empty  in  1  converter FIFO empty.
- i_sof_at_head  in  1  FIFO head word is valid with tuser=1.
- i_fval  in  1  frame-valid level from the SDI timing generator.
- i_data_req  in  1  timing generator requesting an active pixel.
- o_video_mode  out  3  mode driven to the timing generator.
- o_path_rst  out  1  reset to the converter FIFO and timing generator.
- o_sdi_enable  out  1  timing-generator enable.
- o_src_sel  out  1  0 = live FIFO data, 1 = test pattern.
- o_mode_ack  out  1  one-cycle pulse when a requested mode is in effect.
- o_mode_err  out  1  one-cycle pulse when a request is rejected.
- o_underrun_cnt  out  8  total underrun frames, saturating.
- o_state  out  2  current FSM state, for status readback.

## Operation
- States (shared-package enum): HOLD=0, PATTERN=1, LIVE=2.
- Frame end: falling edge of i_fval. Detected from a registered copy fval_d (i_fval==0 && fval_d==1).
- HOLD:
  - o_path_rst=1, o_sdi_enable=0, o_src_sel=1.
  - A cycle counter runs from 0 to RST_CYCLES-1, then the FSM moves to PATTERN.
  - If a request was applied on HOLD entry, o_mode_ack pulses on the exit cycle.
- PATTERN:
  - o_path_rst=0, o_sdi_enable=1, o_src_sel=1.
  - At frame end, if i_fifo_rd_count ≥ FILL_THRESH and i_sof_at_head=1: go to LIVE and clear the consecutive-underrun count.
- LIVE:
  - o_src_sel=0.
  - Underrun: i_data_req && i_fifo_empty. Sets a per-frame flag; counted at most once per frame.
  - At frame end with the flag set: consec+1, o_underrun_cnt+1 (saturating at 255).
  - At frame end with the flag clear: consec=0.
  - When consec reaches UNDERRUN_LIMIT at frame end: go to PATTERN.
  - The flag clears at every frame end.
- Mode requests:
  - Valid modes are 0–4 (package constant MODE_MAX=4).
  - A request with i_mode_req > 4 is dropped and o_mode_err pulses on the next cycle.
  - A valid request is latched into pending (the newest overwrites any older pending).
  - Applying a pending request sets o_video_mode, clears pending, and enters HOLD with the counter at 0.
  - In PATTERN/LIVE, pending is applied at the next frame end.
  - In HOLD, pending is applied on the HOLD exit cycle instead of going to PATTERN. HOLD restarts, and only the final mode is acked.
  - A request equal to the current mode is still applied (forces a path reset).
- Simultaneous events at a frame end: a pending mode change wins over both the LIVE entry and the fallback transitions.

## Timing
- All outputs are registered.
- Reset values: state=HOLD, counter=0, o_video_mode=DEFAULT_MODE, o_path_rst=1, o_sdi_enable=0, o_src_sel=1, o_mode_ack=0, o_mode_err=0, o_underrun_cnt=0, consec=0, pending empty.
- Reset asserted mid-operation returns everything to reset values on the next clock. The full HOLD sequence then runs again.
- Frame-end detection latency: 1 clock after i_fval falls. Outputs change 1 clock after detection.
- o_path_rst is high for exactly RST_CYCLES clocks per HOLD pass. o_sdi_enable rises in the same cycle o_path_rst falls.
- o_src_sel changes only on the frame-end+1 cycle or on HOLD entry.

## Structure
- Shared package sdi_pkg: state enum, MODE_MAX, mode encodings (shared with the pattern generator).
- Sub-module sdi_frame_edge: registers i_fval and outputs single-cycle frame_start/frame_end pulses. It is reused by other SDI blocks.
- Target size: about 200 lines of RTL.

## Test plan
- Reset, RST_CYCLES=16 → o_path_rst high for 16 clocks. Then o_sdi_enable=1, o_src_sel=1, o_state=PATTERN.
- PATTERN with rd_count=8000 and sof_at_head=1 at frame end → o_src_sel=0 one clock after detection. With rd_count=7999 → stays at 1.
- LIVE with underruns in 3 consecutive frames → o_underrun_cnt=3 and o_src_sel=1 after the third frame end. Underrun in frames 1 and 3 only → stays LIVE, o_underrun_cnt=2.
- Mode request 2 mid-frame → o_video_mode=2 at frame end + HOLD of 16 clocks, then o_mode_ack pulse. Request 7 → o_mode_err pulse, mode unchanged.
- Requests 1 then 3 during HOLD → second HOLD pass, o_video_mode=3, a single o_mode_ack.
- 300 underrun frames with UNDERRUN_LIMIT=255 → o_underrun_cnt saturates at 255. i_rst mid-LIVE → all reset values next clock.

Source files
------------

// File: rtl/sdi_pkg.sv
// Shared SDI definitions: controller states, video-mode encodings and mode range check.
package sdi_pkg;

  localparam int unsigned MODE_W = 3;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_PATTERN = 2'd1,
    ST_LIVE    = 2'd2
  } sdi_state_e;

  typedef enum logic [MODE_W-1:0] {
    MODE_720P50  = 3'd0,
    MODE_720P60  = 3'd1,
    MODE_1080I50 = 3'd2,
    MODE_1080I60 = 3'd3,
    MODE_1080P30 = 3'd4
  } sdi_mode_e;

  localparam logic [MODE_W-1:0] MODE_MAX = MODE_1080P30;

  // True when the encoding names a supported video mode.
  function automatic logic mode_is_valid(input logic [MODE_W-1:0] mode);
    return mode <= MODE_MAX;
  endfunction

endpackage

// File: rtl/sdi_frame_edge.sv
// Registers the frame-valid level and emits one-cycle frame start/end pulses.
module sdi_frame_edge (
  input  logic i_sdi_clk,
  input  logic i_rst,
  input  logic i_fval,
  output logic o_frame_start,
  output logic o_frame_end
);

  logic fval_d;

  // Edge detection against the previous fval sample.
  always_ff @(posedge i_sdi_clk) begin
    if (i_rst) begin
      fval_d        <= 1'b0;
      o_frame_start <= 1'b0;
      o_frame_end   <= 1'b0;
    end else begin
      fval_d        <= i_fval;
      o_frame_start <= i_fval & ~fval_d;
      o_frame_end   <= ~i_fval & fval_d;
    end
  end

endmodule

// File: rtl/sdi_tx_ctrl.sv
// HD-SDI transmit controller: path reset, mode switching and live/pattern source
// selection, with every switch aligned to a frame boundary.
module sdi_tx_ctrl
  import sdi_pkg::*;
#(
  parameter int unsigned       FILL_THRESH    = 8000,
  parameter int unsigned       RST_CYCLES     = 16,
  parameter int unsigned       UNDERRUN_LIMIT = 3,
  parameter logic [MODE_W-1:0] DEFAULT_MODE   = 3'd0
) (
  input  logic              i_sdi_clk,
  input  logic              i_rst,
  input  logic [MODE_W-1:0] i_mode_req,
  input  logic              i_mode_req_vld,
  input  logic [13:0]       i_fifo_rd_count,
  input  logic              i_fifo_empty,
  input  logic              i_sof_at_head,
  input  logic              i_fval,
  input  logic              i_data_req,
  output logic [MODE_W-1:0] o_video_mode,
  output logic              o_path_rst,
  output logic              o_sdi_enable,
  output logic              o_src_sel,
  output logic              o_mode_ack,
  output logic              o_mode_err,
  output logic [7:0]        o_underrun_cnt,
  output logic [1:0]        o_state
);

  localparam int unsigned      CNT_W    = $clog2(RST_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [13:0]      THRESH   = 14'(FILL_THRESH);
  localparam logic [7:0]       ULIM     = 8'(UNDERRUN_LIMIT);

  sdi_state_e        state;
  logic [CNT_W-1:0]  cnt;
  logic              ack_due;
  logic              pend_vld;
  logic [MODE_W-1:0] pend_mode;
  logic [7:0]        consec;
  logic              uflag;
  logic              frame_end;
  logic              frame_start_unused;

  logic              underrun_c;
  logic              frame_bad_c;
  logic              hold_done_c;
  logic              apply_c;
  logic              live_ok_c;
  logic [7:0]        consec_inc_c;
  logic              fallback_c;

  sdi_frame_edge u_frame_edge (
    .i_sdi_clk     (i_sdi_clk),
    .i_rst         (i_rst),
    .i_fval        (i_fval),
    .o_frame_start (frame_start_unused),
    .o_frame_end   (frame_end)
  );

  assign o_state = state;

  // Per-cycle decisions shared by the state register block.
  always_comb begin
    underrun_c   = (state == ST_LIVE) && i_data_req && i_fifo_empty;
    frame_bad_c  = uflag || underrun_c;
    hold_done_c  = (state == ST_HOLD) && (cnt == CNT_LAST);
    apply_c      = pend_vld && (hold_done_c || (frame_end && (state != ST_HOLD)));
    live_ok_c    = (i_fifo_rd_count >= THRESH) && i_sof_at_head;
    consec_inc_c = (consec == 8'hFF) ? consec : consec + 8'd1;
    fallback_c   = frame_bad_c && (consec_inc_c >= ULIM);
  end

  // Controller state, registered outputs, underrun accounting and pending mode.
  always_ff @(posedge i_sdi_clk) begin
    if (i_rst) begin
      state          <= ST_HOLD;
      cnt            <= '0;
      o_video_mode   <= DEFAULT_MODE;
      o_path_rst     <= 1'b1;
      o_sdi_enable   <= 1'b0;
      o_src_sel      <= 1'b1;
      o_mode_ack     <= 1'b0;
      o_mode_err     <= 1'b0;
      o_underrun_cnt <= '0;
      ack_due        <= 1'b0;
      pend_vld       <= 1'b0;
      pend_mode      <= DEFAULT_MODE;
      consec         <= '0;
      uflag          <= 1'b0;
    end else begin
      o_mode_ack <= 1'b0;
      o_mode_err <= 1'b0;

      if (apply_c) begin
        state        <= ST_HOLD;
        cnt          <= '0;
        o_video_mode <= pend_mode;
        ack_due      <= 1'b1;
        o_path_rst   <= 1'b1;
        o_sdi_enable <= 1'b0;
        o_src_sel    <= 1'b1;
      end else begin
        case (state)
          ST_HOLD: begin
            if (hold_done_c) begin
              state        <= ST_PATTERN;
              o_path_rst   <= 1'b0;
              o_sdi_enable <= 1'b1;
              o_src_sel    <= 1'b1;
              o_mode_ack   <= ack_due;
              ack_due      <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_PATTERN: begin
            if (frame_end && live_ok_c) begin
              state     <= ST_LIVE;
              o_src_sel <= 1'b0;
            end
          end
          ST_LIVE: begin
            if (frame_end && fallback_c) begin
              state     <= ST_PATTERN;
              o_src_sel <= 1'b1;
            end
          end
          default: begin
            state        <= ST_HOLD;
            cnt          <= '0;
            o_path_rst   <= 1'b1;
            o_sdi_enable <= 1'b0;
            o_src_sel    <= 1'b1;
          end
        endcase
      end

      // Underrun frames are tallied once per frame, only while live.
      if ((state == ST_LIVE) && frame_end) begin
        if (frame_bad_c) begin
          consec <= consec_inc_c;
          if (o_underrun_cnt != 8'hFF) o_underrun_cnt <= o_underrun_cnt + 8'd1;
        end else begin
          consec <= '0;
        end
      end else if ((state == ST_PATTERN) && frame_end && live_ok_c) begin
        consec <= '0;
      end

      if (frame_end) uflag <= 1'b0;
      else if (underrun_c) uflag <= 1'b1;

      // A new request lands after any apply this cycle, so it is never lost.
      if (apply_c) pend_vld <= 1'b0;
      if (i_mode_req_vld) begin
        if (mode_is_valid(i_mode_req)) begin
          pend_vld  <= 1'b1;
          pend_mode <= i_mode_req;
        end else begin
          o_mode_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sdi_tx_ctrl.sv
// Self-checking bench for sdi_tx_ctrl: directed tables, corner sequences and a
// randomized run compared against a frame-level reference model.
module tb_sdi_tx_ctrl;

  localparam int RST_CYC = 16;
  localparam int THRESH  = 8000;
  localparam int LIMIT   = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        i_rst = 1'b1;
  logic [2:0]  i_mode_req = '0;
  logic        i_mode_req_vld = 1'b0;
  logic [13:0] i_fifo_rd_count = '0;
  logic        i_fifo_empty = 1'b0;
  logic        i_sof_at_head = 1'b0;
  logic        i_fval = 1'b0;
  logic        i_data_req = 1'b0;

  logic [2:0]  o_video_mode;
  logic        o_path_rst, o_sdi_enable, o_src_sel, o_mode_ack, o_mode_err;
  logic [7:0]  o_underrun_cnt;
  logic [1:0]  o_state;

  logic [2:0]  sat_unused_mode;
  logic        sat_unused_rst, sat_unused_en, sat_unused_src, sat_unused_ack, sat_unused_err;
  logic [7:0]  sat_ucnt;
  logic [1:0]  sat_state;

  sdi_tx_ctrl dut (
    .i_sdi_clk(clk), .i_rst(i_rst), .i_mode_req(i_mode_req), .i_mode_req_vld(i_mode_req_vld),
    .i_fifo_rd_count(i_fifo_rd_count), .i_fifo_empty(i_fifo_empty), .i_sof_at_head(i_sof_at_head),
    .i_fval(i_fval), .i_data_req(i_data_req), .o_video_mode(o_video_mode), .o_path_rst(o_path_rst),
    .o_sdi_enable(o_sdi_enable), .o_src_sel(o_src_sel), .o_mode_ack(o_mode_ack),
    .o_mode_err(o_mode_err), .o_underrun_cnt(o_underrun_cnt), .o_state(o_state)
  );

  sdi_tx_ctrl #(.UNDERRUN_LIMIT(255)) dut_sat (
    .i_sdi_clk(clk), .i_rst(i_rst), .i_mode_req(i_mode_req), .i_mode_req_vld(i_mode_req_vld),
    .i_fifo_rd_count(i_fifo_rd_count), .i_fifo_empty(i_fifo_empty), .i_sof_at_head(i_sof_at_head),
    .i_fval(i_fval), .i_data_req(i_data_req), .o_video_mode(sat_unused_mode), .o_path_rst(sat_unused_rst),
    .o_sdi_enable(sat_unused_en), .o_src_sel(sat_unused_src), .o_mode_ack(sat_unused_ack),
    .o_mode_err(sat_unused_err), .o_underrun_cnt(sat_ucnt), .o_state(sat_state)
  );

  int n_checks = 0;
  int n_errs   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: 0 = hold, 1 = pattern, 2 = live; outputs follow from the state.
  int m_st = 0, m_hold_n = 1, m_mode = 0, m_pend_mode = 0, m_ucnt = 0, m_consec = 0;
  bit m_pend = 0, m_ack_due = 0, m_ack = 0, m_err = 0, m_bad = 0;
  bit h1 = 0, h2 = 0;

  always @(posedge clk) begin
    bit fe, und, go_hold;
    if (i_rst) begin
      m_st = 0; m_hold_n = 1; m_mode = 0; m_pend = 0; m_ack_due = 0; m_ack = 0; m_err = 0;
      m_ucnt = 0; m_consec = 0; m_bad = 0; h1 = 0; h2 = 0;
    end else begin
      fe = !h1 && h2;
      h2 = h1;
      h1 = i_fval;
      und = (m_st == 2) && i_data_req && i_fifo_empty;
      m_ack = 0;
      m_err = 0;
      go_hold = m_pend && ((m_st == 0 && m_hold_n == RST_CYC) || (m_st != 0 && fe));
      if (m_st == 2 && fe) begin
        if (m_bad || und) begin
          m_consec = (m_consec < 255) ? m_consec + 1 : 255;
          m_ucnt   = (m_ucnt < 255) ? m_ucnt + 1 : 255;
        end else m_consec = 0;
      end
      if (go_hold) begin
        m_st = 0; m_hold_n = 1; m_mode = m_pend_mode; m_pend = 0; m_ack_due = 1;
      end else if (m_st == 0) begin
        if (m_hold_n == RST_CYC) begin m_st = 1; m_ack = m_ack_due; m_ack_due = 0; end
        else m_hold_n++;
      end else if (m_st == 1 && fe && int'(i_fifo_rd_count) >= THRESH && i_sof_at_head) begin
        m_st = 2; m_consec = 0;
      end else if (m_st == 2 && fe && m_consec >= LIMIT) begin
        m_st = 1;
      end
      m_bad = fe ? 1'b0 : (m_bad || und);
      if (i_mode_req_vld) begin
        if (i_mode_req <= 3'd4) begin m_pend = 1; m_pend_mode = int'(i_mode_req); end
        else m_err = 1;
      end
    end
  end

  // Every cycle, the whole registered output set must match the model.
  always @(negedge clk) begin
    logic [18:0] exp_v, act_v;
    if (chk_en) begin
      exp_v = {2'(m_st), 3'(m_mode), (m_st == 0), (m_st != 0), (m_st != 2), m_ack, m_err, 8'(m_ucnt)};
      act_v = {o_state, o_video_mode, o_path_rst, o_sdi_enable, o_src_sel, o_mode_ack, o_mode_err,
               o_underrun_cnt};
      chk("model", 32'(act_v), 32'(exp_v));
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      i_fval = 1'b0; i_data_req = 1'b0; i_fifo_empty = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic frame_body(input int act, input int nund);
    for (int i = 0; i < act; i++) begin
      i_fval = 1'b1; i_data_req = 1'b1; i_fifo_empty = (i < nund);
      @(negedge clk);
    end
    i_data_req = 1'b0; i_fifo_empty = 1'b0;
  endtask

  task automatic frame(input int act, input int nund);
    frame_body(act, nund);
    idle(4);
  endtask

  task automatic do_reset();
    i_mode_req_vld = 1'b0;
    i_rst = 1'b1;
    idle(2);
    i_rst = 1'b0;
  endtask

  task automatic wait_hold(output int n, output int acks);
    n = 0; acks = 0;
    while (o_path_rst && n < 200) begin
      n++;
      idle(1);
      acks += int'(o_mode_ack);
    end
  endtask

  task automatic req(input logic [2:0] m);
    i_mode_req = m; i_mode_req_vld = 1'b1;
    idle(1);
    i_mode_req_vld = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_state"}, 32'(o_state), 0);
    chk({tag, "_mode"}, 32'(o_video_mode), 0);
    chk({tag, "_path_rst"}, 32'(o_path_rst), 1);
    chk({tag, "_enable"}, 32'(o_sdi_enable), 0);
    chk({tag, "_src_sel"}, 32'(o_src_sel), 1);
    chk({tag, "_ack"}, 32'(o_mode_ack), 0);
    chk({tag, "_err"}, 32'(o_mode_err), 0);
    chk({tag, "_ucnt"}, 32'(o_underrun_cnt), 0);
  endtask

  typedef struct {
    logic [13:0] rd_count;
    logic        sof;
    logic        exp_src;
  } live_vec_t;

  live_vec_t vecs[6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n, acks;
    vecs[0] = '{14'd8000,  1'b1, 1'b0};
    vecs[1] = '{14'd7999,  1'b1, 1'b1};
    vecs[2] = '{14'd8000,  1'b0, 1'b1};
    vecs[3] = '{14'd16383, 1'b1, 1'b0};
    vecs[4] = '{14'd0,     1'b0, 1'b1};
    vecs[5] = '{14'd8001,  1'b1, 1'b0};

    @(negedge clk);
    do_reset();
    chk_en = 1'b1;
    check_reset_vals("rst");
    wait_hold(n, acks);
    chk("hold_len", 32'(n), RST_CYC);
    chk("hold_state", 32'(o_state), 1);
    chk("hold_enable", 32'(o_sdi_enable), 1);
    chk("hold_src", 32'(o_src_sel), 1);
    chk("hold_no_ack", 32'(acks), 0);

    // Live-entry decision at a frame end for each fill/SOF combination.
    foreach (vecs[v]) begin
      do_reset();
      wait_hold(n, acks);
      i_fifo_rd_count = vecs[v].rd_count;
      i_sof_at_head   = vecs[v].sof;
      frame_body(8, 0);
      idle(1);
      chk("live_detect_src", 32'(o_src_sel), 1);
      idle(1);
      chk("live_src", 32'(o_src_sel), 32'(vecs[v].exp_src));
      chk("live_state", 32'(o_state), vecs[v].exp_src ? 1 : 2);
      idle(2);
    end

    // Three consecutive underrun frames fall back to pattern.
    do_reset();
    wait_hold(n, acks);
    i_fifo_rd_count = 14'd8000; i_sof_at_head = 1'b1;
    frame(8, 0);
    i_fifo_rd_count = 14'd0;
    chk("u3_live", 32'(o_src_sel), 0);
    frame(8, 1);
    frame(8, 1);
    chk("u3_still_live", 32'(o_state), 2);
    chk("u3_cnt2", 32'(o_underrun_cnt), 2);
    frame(8, 1);
    chk("u3_cnt", 32'(o_underrun_cnt), 3);
    chk("u3_src", 32'(o_src_sel), 1);
    chk("u3_state", 32'(o_state), 1);

    // Non-consecutive underruns, one frame with several underrun cycles.
    do_reset();
    wait_hold(n, acks);
    i_fifo_rd_count = 14'd8000; i_sof_at_head = 1'b1;
    frame(8, 0);
    i_fifo_rd_count = 14'd0;
    frame(8, 5);
    chk("u13_once", 32'(o_underrun_cnt), 1);
    frame(8, 0);
    frame(8, 1);
    chk("u13_state", 32'(o_state), 2);
    chk("u13_cnt", 32'(o_underrun_cnt), 2);

    // Mode request mid-frame is applied at the frame end.
    frame_body(3, 0);
    i_mode_req = 3'd2; i_mode_req_vld = 1'b1;
    frame_body(1, 0);
    i_mode_req_vld = 1'b0;
    frame_body(3, 0);
    idle(1);
    chk("mode_before", 32'(o_video_mode), 0);
    idle(1);
    chk("mode_applied", 32'(o_video_mode), 2);
    chk("mode_hold_rst", 32'(o_path_rst), 1);
    chk("mode_hold_src", 32'(o_src_sel), 1);
    wait_hold(n, acks);
    chk("mode_hold_len", 32'(n), RST_CYC);
    chk("mode_ack_cnt", 32'(acks), 1);
    chk("mode_state", 32'(o_state), 1);
    idle(1);
    chk("mode_ack_pulse", 32'(o_mode_ack), 0);
    chk("mode_ucnt_kept", 32'(o_underrun_cnt), 2);

    // Out-of-range requests are rejected and leave nothing pending.
    req(3'd7);
    chk("err7_pulse", 32'(o_mode_err), 1);
    idle(1);
    chk("err7_clear", 32'(o_mode_err), 0);
    req(3'd5);
    chk("err5_pulse", 32'(o_mode_err), 1);
    frame(8, 0);
    chk("err_mode", 32'(o_video_mode), 2);
    chk("err_no_hold", 32'(o_path_rst), 0);

    // Two requests during HOLD: one restart, final mode, single ack.
    do_reset();
    req(3'd1);
    idle(2);
    req(3'd3);
    wait_hold(n, acks);
    chk("dbl_hold_len", 32'(n), 2 * RST_CYC - 4);
    chk("dbl_mode", 32'(o_video_mode), 3);
    chk("dbl_acks", 32'(acks), 1);

    // Reset in LIVE with a request pending.
    do_reset();
    wait_hold(n, acks);
    i_fifo_rd_count = 14'd8000; i_sof_at_head = 1'b1;
    frame(8, 0);
    i_fifo_rd_count = 14'd0;
    frame(8, 1);
    chk("mr_ucnt", 32'(o_underrun_cnt), 1);
    req(3'd4);
    i_rst = 1'b1;
    idle(1);
    check_reset_vals("midrst");
    i_rst = 1'b0;
    wait_hold(n, acks);
    chk("midrst_hold", 32'(n), RST_CYC);
    frame(8, 0);
    chk("midrst_no_pend", 32'(o_video_mode), 0);
    chk("midrst_path", 32'(o_path_rst), 0);

    // Saturation on the instance with a 255-frame fallback limit.
    do_reset();
    wait_hold(n, acks);
    i_fifo_rd_count = 14'd8000; i_sof_at_head = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      frame(6, 1);
      if (k == 255) begin
        chk("sat_254", 32'(sat_ucnt), 254);
        chk("sat_live", 32'(sat_state), 2);
      end
      if (k == 256) chk("sat_fallback", 32'(sat_state), 1);
    end
    chk("sat_255", 32'(sat_ucnt), 255);

    // Randomized frames, requests and resets against the model.
    do_reset();
    for (int f = 0; f < 150; f++) begin
      int act, blank, pick;
      pick = $urandom_range(3);
      i_fifo_rd_count = (pick == 0) ? 14'd7999 : (pick == 1) ? 14'd8000 :
                        (pick == 2) ? 14'd16383 : 14'($urandom_range(16383));
      i_sof_at_head = ($urandom_range(3) != 0);
      if ($urandom_range(99) == 0) begin
        i_mode_req_vld = 1'b0;
        i_rst = 1'b1;
        idle(1);
        i_rst = 1'b0;
      end
      act = $urandom_range(12, 3);
      blank = $urandom_range(6, 2);
      for (int c = 0; c < act + blank; c++) begin
        i_fval       = (c < act);
        i_data_req   = (c < act) && ($urandom_range(3) != 0);
        i_fifo_empty = ($urandom_range(15) == 0);
        i_mode_req_vld = ($urandom_range(59) == 0);
        i_mode_req   = 3'($urandom_range(7));
        @(negedge clk);
      end
    end
    i_mode_req_vld = 1'b0;
    idle(4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
